// File: rtl/alarm_pkg.sv
// Shared constants for the alarm controller and the time-of-day counter.
package alarm_pkg;

  // Controller state encoding; the values are visible on the State port.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] RINGING = 2'd2;
  localparam logic [1:0] SNOOZED = 2'd3;

  // Calendar limits, shared with the upstream time counter.
  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;

  // Hours:minutes pair, used for the stored alarm and the snooze target.
  typedef struct packed {
    logic [5:0] h;
    logic [5:0] m;
  } hm_t;

endpackage

// File: rtl/time_add_mins.sv
// Combinational hours:minutes + N, wrapping at 24 hours.
module time_add_mins
  import alarm_pkg::*;
#(
  parameter int unsigned N = 9
) (
  input  logic [5:0] hours_i,
  input  logic [5:0] mins_i,
  output logic [5:0] hours_o,
  output logic [5:0] mins_o
);

  logic [6:0] m_sum;

  // Add N minutes; on minute overflow carry into the hour, 23 wraps to 0.
  always_comb begin
    m_sum   = {1'b0, mins_i} + 7'(N);
    mins_o  = m_sum[5:0];
    hours_o = hours_i;
    if (m_sum >= 7'd60) begin
      mins_o  = 6'(m_sum - 7'd60);
      hours_o = (hours_i >= HOUR_MAX) ? 6'd0 : hours_i + 6'd1;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: stored alarm time, arm/stop/snooze FSM, ring timeout.
// One clock cycle is one second of the upstream HH:MM:SS counter.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_MINS = 9,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [5:0] Hours,
  input  logic [5:0] Mins,
  input  logic [5:0] Secs,
  input  logic       set_valid,
  input  logic [5:0] set_hours,
  input  logic [5:0] set_mins,
  output logic       set_ready,
  output logic       set_err,
  input  logic       arm,
  input  logic       snooze,
  input  logic       stop,
  output logic       Ring,
  output logic [1:0] State,
  output logic [1:0] Snooze_cnt,
  output logic [5:0] Alarm_hours,
  output logic [5:0] Alarm_mins
);

  logic [1:0] state_q, state_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic [1:0] snooze_cnt_q, snooze_cnt_d;
  hm_t        alarm_q, alarm_d;
  hm_t        snz_tgt_q, snz_tgt_d;
  logic       set_err_q, set_err_d;
  logic       ring_q, ring_d;

  hm_t        snz_next;
  hm_t        tgt;
  logic       match;
  logic       load;

  // Snooze target is computed from the time presented in the snooze cycle.
  time_add_mins #(.N(SNOOZE_MINS)) u_snz_add (
    .hours_i (Hours),
    .mins_i  (Mins),
    .hours_o (snz_next.h),
    .mins_o  (snz_next.m)
  );

  assign set_ready = (state_q == IDLE) || (state_q == ARMED);
  assign load      = set_valid && set_ready;

  // Compare against the snooze target while snoozed, else the stored alarm
  // (the old stored value, so a same-cycle load does not hide a match).
  always_comb begin
    tgt   = (state_q == SNOOZED) ? snz_tgt_q : alarm_q;
    match = (Hours == tgt.h) && (Mins == tgt.m) && (Secs == 6'd0);
  end

  // Next-state logic: arm==0 > stop > snooze > timeout/match in every state.
  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    alarm_d      = alarm_q;
    snz_tgt_d    = snz_tgt_q;
    set_err_d    = 1'b0;

    if (load) begin
      if (set_hours <= HOUR_MAX && set_mins <= MIN_MAX) begin
        alarm_d.h = set_hours;
        alarm_d.m = set_mins;
      end else begin
        set_err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        if (!arm) begin
          state_d = IDLE;
        end else if (match) begin
          state_d    = RINGING;
          ring_cnt_d = 8'd0;
        end
      end
      RINGING: begin
        if (!arm) begin
          state_d = IDLE;
        end else if (stop) begin
          state_d = ARMED;
        end else if (snooze) begin
          // Snooze budget exhausted: the request behaves like stop.
          if (snooze_cnt_q < 2'(MAX_SNOOZE)) begin
            state_d      = SNOOZED;
            snooze_cnt_d = snooze_cnt_q + 2'd1;
            snz_tgt_d    = snz_next;
          end else begin
            state_d = ARMED;
          end
        end else if (ring_cnt_q == 8'(RING_SECS - 1)) begin
          state_d = ARMED;
        end else begin
          ring_cnt_d = ring_cnt_q + 8'd1;
        end
      end
      SNOOZED: begin
        if (!arm) begin
          state_d = IDLE;
        end else if (stop) begin
          state_d = ARMED;
        end else if (match) begin
          state_d    = RINGING;
          ring_cnt_d = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new alarm event starts with a fresh snooze budget.
    if (state_d == IDLE || state_d == ARMED) snooze_cnt_d = 2'd0;
  end

  // Ring is registered from the next state so it tracks State exactly.
  always_comb ring_d = (state_d == RINGING);

  // State registers; reset drops Ring and discards any snooze target.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      ring_cnt_q   <= 8'd0;
      snooze_cnt_q <= 2'd0;
      alarm_q      <= '0;
      snz_tgt_q    <= '0;
      set_err_q    <= 1'b0;
      ring_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ring_cnt_q   <= ring_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      alarm_q      <= alarm_d;
      snz_tgt_q    <= snz_tgt_d;
      set_err_q    <= set_err_d;
      ring_q       <= ring_d;
    end
  end

  assign State       = state_q;
  assign Ring        = ring_q;
  assign Snooze_cnt  = snooze_cnt_q;
  assign Alarm_hours = alarm_q.h;
  assign Alarm_mins  = alarm_q.m;
  assign set_err     = set_err_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed scenarios plus random
// stimulus, compared every cycle against a minutes-of-day reference model.
module tb_alarm_ctrl;

  localparam int RING_SECS   = 60;
  localparam int SNOOZE_MINS = 9;
  localparam int MAX_SNOOZE  = 3;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [5:0] Hours, Mins, Secs;
  logic       set_valid;
  logic [5:0] set_hours, set_mins;
  logic       set_ready, set_err;
  logic       arm, snooze, stop;
  logic       Ring;
  logic [1:0] State, Snooze_cnt;
  logic [5:0] Alarm_hours, Alarm_mins;

  alarm_ctrl #(.RING_SECS(RING_SECS), .SNOOZE_MINS(SNOOZE_MINS), .MAX_SNOOZE(MAX_SNOOZE)) dut (
    .CLK(CLK), .RST_N(RST_N), .Hours(Hours), .Mins(Mins), .Secs(Secs),
    .set_valid(set_valid), .set_hours(set_hours), .set_mins(set_mins),
    .set_ready(set_ready), .set_err(set_err), .arm(arm), .snooze(snooze),
    .stop(stop), .Ring(Ring), .State(State), .Snooze_cnt(Snooze_cnt),
    .Alarm_hours(Alarm_hours), .Alarm_mins(Alarm_mins)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;
  int tod = 0;          // bench time of day in seconds, 0..86399

  // Reference model: states 0 idle, 1 armed, 2 ringing, 3 snoozed.
  // Times kept as minutes of day; ring measured as seconds left to sound.
  int m_st, m_left, m_used, m_al, m_snz, m_err;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_st = 0; m_left = 0; m_used = 0; m_al = 0; m_snz = 0; m_err = 0;
  endtask

  task automatic model_next();
    int cur, nst, al_n, err_n;
    bit sec0;
    cur   = int'(Hours) * 60 + int'(Mins);
    sec0  = (Secs == 0);
    al_n  = m_al;
    err_n = 0;
    if (set_valid && m_st < 2) begin
      if (set_hours <= 23 && set_mins <= 59) al_n = int'(set_hours) * 60 + int'(set_mins);
      else err_n = 1;
    end
    nst = m_st;
    case (m_st)
      0: if (arm) nst = 1;
      1: if (!arm) nst = 0;
         else if (sec0 && cur == m_al) begin nst = 2; m_left = RING_SECS; end
      2: if (!arm) nst = 0;
         else if (stop) nst = 1;
         else if (snooze) begin
           if (m_used < MAX_SNOOZE) begin
             nst = 3; m_used++; m_snz = (cur + SNOOZE_MINS) % 1440;
           end else nst = 1;
         end else begin
           m_left--;
           if (m_left == 0) nst = 1;
         end
      default: if (!arm) nst = 0;
         else if (stop) nst = 1;
         else if (sec0 && cur == m_snz) begin nst = 2; m_left = RING_SECS; end
    endcase
    if (nst < 2) m_used = 0;
    m_st = nst; m_al = al_n; m_err = err_n;
  endtask

  task automatic chk_all();
    chk("state", State, m_st);
    chk("ring", Ring, (m_st == 2) ? 1 : 0);
    chk("snooze_cnt", Snooze_cnt, m_used);
    chk("alarm_hours", Alarm_hours, m_al / 60);
    chk("alarm_mins", Alarm_mins, m_al % 60);
    chk("set_err", set_err, m_err);
    chk("set_ready", set_ready, (m_st < 2) ? 1 : 0);
  endtask

  // One second: present tod, predict, clock, compare, advance, clear pulses.
  task automatic step();
    Hours = 6'(tod / 3600);
    Mins  = 6'((tod / 60) % 60);
    Secs  = 6'(tod % 60);
    model_next();
    @(posedge CLK); #1;
    chk_all();
    tod = (tod + 1) % 86400;
    snooze = 1'b0; stop = 1'b0; set_valid = 1'b0;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    RST_N = 1'b0;
    snooze = 1'b0; stop = 1'b0; set_valid = 1'b0;
    #1;
    model_reset();
    chk_all();
    @(posedge CLK); #1;
    RST_N = 1'b1;
  endtask

  task automatic load(input int h, input int m);
    set_valid = 1'b1; set_hours = 6'(h); set_mins = 6'(m);
  endtask

  function automatic int hms(input int h, input int m, input int s);
    return h * 3600 + m * 60 + s;
  endfunction

  initial begin
    int ring_n, t0, r, tgt;
    RST_N = 1'b0; arm = 1'b0; snooze = 1'b0; stop = 1'b0;
    set_valid = 1'b0; set_hours = '0; set_mins = '0;
    Hours = '0; Mins = '0; Secs = '0;
    #2;
    do_reset();

    // Load 06:30 in idle, arm, ring for exactly RING_SECS cycles.
    load(6, 30); step();
    arm = 1'b1; tod = hms(6, 29, 58); step(); step();
    ring_n = 0;
    for (int i = 0; i < 70; i++) begin step(); ring_n += int'(Ring); end
    chk("ring_len", ring_n, RING_SECS);
    chk("after_timeout", State, 1);

    // Snooze at 06:30:05, rings again at 06:39:00.
    tod = hms(6, 29, 59); step(); step();
    for (int i = 0; i < 4; i++) step();
    snooze = 1'b1; step();
    chk("snz1_state", State, 3); chk("snz1_ring", Ring, 0); chk("snz1_cnt", Snooze_cnt, 1);
    tod = hms(6, 38, 58); step(); step(); step();
    chk("snz1_rering", Ring, 1);

    // Alarm 23:55, snooze at 23:55:10 wraps to 00:04:00.
    stop = 1'b1; step();
    load(23, 55); step();
    tod = hms(23, 54, 59); step(); step();
    for (int i = 0; i < 9; i++) step();
    snooze = 1'b1; step();
    tod = hms(0, 3, 59); step();
    chk("wrap_before", Ring, 0);
    step();
    chk("wrap_ring", Ring, 1);
    stop = 1'b1; step();

    // Four snoozes in one event: the fourth behaves like stop.
    tod = hms(23, 54, 59); step(); step();
    for (int k = 0; k < 4; k++) begin
      t0 = tod; snooze = 1'b1; step();
      if (k < 3) begin
        chk("snz_k_state", State, 3);
        tod = ((t0 / 60 + SNOOZE_MINS) * 60 - 1 + 86400) % 86400;
        step(); step();
      end
    end
    chk("snz4_state", State, 1); chk("snz4_cnt", Snooze_cnt, 0);

    // Out-of-range loads pulse set_err for one cycle, alarm kept.
    load(24, 0); step();
    chk("err_h", set_err, 1); chk("err_h_keep", Alarm_hours, 23);
    step(); chk("err_clear", set_err, 0);
    load(5, 60); step();
    chk("err_m", set_err, 1); chk("err_m_keep", Alarm_mins, 55);
    // Load attempted while ringing is ignored.
    tod = hms(23, 54, 59); step(); step();
    chk("ready_ringing", set_ready, 0);
    load(5, 5); step();
    chk("ring_load_h", Alarm_hours, 23); chk("ring_load_m", Alarm_mins, 55);
    stop = 1'b1; step();

    // Load coinciding with a match: rings on old value, stores new one.
    tod = hms(23, 55, 0); load(1, 0); step();
    chk("sim_ring", Ring, 1); chk("sim_new_h", Alarm_hours, 1);
    // Arming exactly at the alarm second does not ring that minute.
    arm = 1'b0; step();
    arm = 1'b1; tod = hms(1, 0, 0); step(); step();
    chk("arm_at_match", State, 1);

    // Reset mid-ring, then disarm while snoozed.
    tod = hms(0, 59, 59); step(); step();
    chk("pre_reset_ring", Ring, 1);
    do_reset();
    load(23, 55); step();
    tod = hms(23, 54, 59); step(); step();
    snooze = 1'b1; step();
    arm = 1'b0; step();
    tod = hms(0, 3, 58);
    for (int i = 0; i < 4; i++) step();
    chk("disarm_no_ring", Ring, 0); chk("disarm_idle", State, 0);

    // Random phase, with time jumps toward the live target to force matches.
    arm = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5) begin
        tgt = (m_st == 3) ? m_snz : m_al;
        tod = (tgt * 60 - int'($urandom_range(0, 2)) + 86400) % 86400;
      end else if (r < 7) begin
        tod = int'($urandom_range(0, 86399));
      end
      if ($urandom_range(0, 49) == 0) arm = ~arm;
      stop   = ($urandom_range(0, 39) == 0);
      snooze = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) load(int'($urandom_range(0, 27)), int'($urandom_range(0, 63)));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Alarm controller sitting directly downstream of the HH:MM:SS time-of-day counter.
- Consumes its Hours/Mins/Secs outputs on the same 1 Hz CLK, so one clock cycle equals one second.
- Holds a programmable alarm time loaded through a valid/ready handshake, and drives a Ring output.
- Supports arm/disarm, stop, a bounded snooze, and a ring timeout.

Parameters:
- RING_SECS, 60: cycles Ring stays high before auto-timeout (range 1..255).
- SNOOZE_MINS, 9: minutes added to the current time on snooze (range 1..59).
- MAX_SNOOZE, 3: snoozes allowed per alarm event (range 0..3).

Ports:
- CLK  in  1  1 Hz system clock, shared with the time counter.
- RST_N  in  1  asynchronous, active-low reset.
- Hours  in  6  current hour, 0..23.
- Mins  in  6  current minute, 0..59.
- Secs  in  6  current second, 0..59.
- set_valid  in  1  alarm-time load request.
- set_hours  in  6  requested alarm hour.
- set_mins  in  6  requested alarm minute.
- set_ready  out  1  block accepts a load this cycle.
- set_err  out  1  one-cycle pulse: the load was rejected.
- arm  in  1  level input; 1 = alarm enabled.
- snooze  in  1  single-cycle request.
- stop  in  1  single-cycle request.
- Ring  out  1  alarm sounding.
- State  out  2  0 IDLE, 1 ARMED, 2 RINGING, 3 SNOOZED.
- Snooze_cnt  out  2  snoozes used in the current event.
- Alarm_hours  out  6  stored alarm hour.
- Alarm_mins  out  6  stored alarm minute.

Behaviour:
- Reset (RST_N low, asynchronous):
  - State=IDLE, Ring=0, Snooze_cnt=0, Alarm_hours=0, Alarm_mins=0, set_err=0.
  - Snooze target=00:00, ring counter=0.
  - set_ready=1 (decoded from State).
- Reset mid-ring drops Ring immediately and discards any snooze target.
- Match condition: Hours==target hour && Mins==target minute && Secs==0.
  - Target is the stored alarm time in ARMED.
  - Target is the snooze target in SNOOZED.
- State transitions. Per-state priority: arm==0 > stop > snooze > timeout/match.
  - IDLE: arm=1 -> ARMED.
  - ARMED:
    - arm=0 -> IDLE.
    - match -> RINGING; ring counter=0.
  - RINGING:
    - arm=0 -> IDLE.
    - stop -> ARMED.
    - snooze with Snooze_cnt<MAX_SNOOZE -> SNOOZED; Snooze_cnt+1; snooze target = (Hours:Mins sampled this cycle) + SNOOZE_MINS.
    - snooze with Snooze_cnt==MAX_SNOOZE is treated as stop.
    - ring counter==RING_SECS-1 -> ARMED (timeout).
    - Otherwise the ring counter increments.
  - SNOOZED:
    - arm=0 -> IDLE.
    - stop -> ARMED.
    - snooze-target match -> RINGING; ring counter=0.
    - snooze input is ignored in this state.
- Snooze_cnt clears to 0 on every entry to ARMED or IDLE.
- Ring: Ring = (State==RINGING), driven from a register.
  - Ring rises the cycle after the calendar presents HH:MM:00.
  - Ring stays high exactly RING_SECS cycles unless interrupted.
- Snooze arithmetic:
  - 7-bit minute sum m = Mins + SNOOZE_MINS.
  - If m >= 60: minutes = m-60 and the hour increments.
  - Hour 23+1 wraps to 0 (e.g. 23:55 + 9 -> 00:04).
- Set handshake:
  - set_ready=1 only in IDLE or ARMED.
  - Transfer occurs when set_valid && set_ready.
  - If set_hours<=23 && set_mins<=59: Alarm_hours/Alarm_mins update at that edge.
  - Otherwise the stored time is unchanged and set_err pulses high for the next cycle.
- Simultaneous load and match in ARMED:
  - Match compares the old stored value, so the alarm rings.
  - The new value is stored and applies to future matches.
- set_valid held while set_ready=0 has no effect; the request is not queued.
- arm asserted while the current time already equals the alarm time at Secs==0: ARMED is entered this cycle, and matching starts from the next cycle, so no ring that minute.

Decomposition:
- Package alarm_pkg:
  - State encoding constants IDLE/ARMED/RINGING/SNOOZED.
  - HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59 (shared with the time counter).
- One sub-module, time_add_mins: combinational hours:minutes + N with 24-hour wrap, used for the snooze target.
- The FSM, counters and handshake stay in alarm_ctrl.

Test Plan:
- Load 06:30 in IDLE, arm=1, drive time 06:29:58 -> 06:30:00 -> Ring rises the cycle after 06:30:00 and stays high 60 cycles, then State=ARMED, Ring=0.
- Ringing, snooze at time 06:30:05 -> State=SNOOZED, Ring=0, Snooze_cnt=1; time 06:39:00 -> Ring=1.
- Alarm 23:55, snooze at 23:55:10 (SNOOZE_MINS=9) -> rings again at 00:04:00.
- Four consecutive snoozes with MAX_SNOOZE=3 -> the fourth acts as stop: State=ARMED, Snooze_cnt=0.
- Load set_hours=24 or set_mins=60 -> set_err=1 for one cycle, Alarm_hours/Alarm_mins unchanged; set_valid during RINGING -> set_ready=0, no change.
- RST_N low mid-ring -> Ring=0 and State=IDLE immediately, all outputs at reset values; arm=0 mid-SNOOZED -> State=IDLE, no later ring.
